board_shuffler: RTL

// - Upstream of the in-game FSM. On each new game, builds a shuffled 4x4 board of 8 tile pairs and writes all 16 words into tile RAM.
// - The menu FSM pulses start; the in-game FSM is enabled only once board_ready is high.
// - Word format matches the in-game FSM: [7:2] tile id, [1] flip, [0] cursor.

---
 rtl/board_pkg.sv | 33 +++
 rtl/board_shuffler_lfsr16.sv | 36 +++
 rtl/board_shuffler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the board shuffler and the in-game FSM tile RAM word format.
package board_pkg;

   localparam int unsigned NUM_TILES = 16;
   localparam int unsigned NUM_PAIRS = 8;

   // Tile RAM word layout: [7:2] tile id, [1] flip, [0] cursor
   localparam int unsigned ID_MSB     = 7;
   localparam int unsigned ID_LSB     = 2;
   localparam int unsigned FLIP_BIT   = 1;
   localparam int unsigned CURSOR_BIT = 0;

   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StFill    = 3'd1,
      StShuffle = 3'd2,
      StWrite   = 3'd3,
      StDone    = 3'd4
   } state_e;

   // Builds a tile RAM word: face-down tile with an optional cursor
   function automatic logic [7:0] make_word(input logic [2:0] id, input logic cursor);
      logic [7:0] w;
      w                 = '0;
      w[ID_MSB:ID_LSB]  = {3'b000, id};
      w[FLIP_BIT]       = 1'b0;
      w[CURSOR_BIT]     = cursor;
      return w;
   endfunction

endpackage

// File: rtl/board_shuffler_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that can never sit in the all-zero state.
module lfsr16
   import board_pkg::*;
(
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   input  logic        step_i,
   output logic [15:0] q_o
);

   logic [15:0] q_q, q_d;

   // Next state: load wins over step; a zero load is swapped for the default seed
   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = (load_val_i == 16'h0000) ? LFSR_DEFAULT : load_val_i;
      end else if (step_i) begin
         q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
      end
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         q_q <= LFSR_DEFAULT;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/board_shuffler.sv
// Builds a shuffled 4x4 board of 8 tile pairs and writes all 16 words into tile RAM.
module board_shuffler
   import board_pkg::*;
#(
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter bit          FIXED_SEED = 1'b0
) (
   input  logic       clk_i,
   input  logic       resetn_i,
   input  logic       start_i,
   output logic [3:0] addr_o,
   output logic [7:0] wdata_o,
   output logic       we_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       board_ready_o
);

   localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? LFSR_DEFAULT : SEED;

   state_e      state_q, state_d;
   logic [2:0]  tile_q [NUM_TILES];
   logic [2:0]  tile_d [NUM_TILES];
   logic [3:0]  i_q, i_d;
   logic [3:0]  k_q, k_d;
   logic [15:0] cnt_q;

   logic [3:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        board_ready_q, board_ready_d;

   logic        lfsr_load;
   logic        lfsr_step;
   logic [15:0] lfsr_load_val;
   logic [15:0] lfsr_q;
   logic [3:0]  j;
   logic        unused_lfsr;

   assign lfsr_load_val = FIXED_SEED ? SeedEff : (SeedEff ^ cnt_q);
   assign j             = lfsr_q[3:0];
   assign unused_lfsr   = ^lfsr_q[15:4];

   lfsr16 u_lfsr (
      .clk_i      (clk_i),
      .resetn_i   (resetn_i),
      .load_i     (lfsr_load),
      .load_val_i (lfsr_load_val),
      .step_i     (lfsr_step),
      .q_o        (lfsr_q)
   );

   // FSM next state, Fisher-Yates swap and registered-output next values
   always_comb begin
      state_d       = state_q;
      tile_d        = tile_q;
      i_d           = i_q;
      k_d           = k_q;
      lfsr_load     = 1'b0;
      lfsr_step     = 1'b0;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      we_d          = 1'b0;
      done_d        = 1'b0;
      board_ready_d = board_ready_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d       = StFill;
               lfsr_load     = 1'b1;
               board_ready_d = 1'b0;
            end
         end
         StFill: begin
            for (int t = 0; t < NUM_TILES; t++) begin
               tile_d[t] = 3'(t >> 1);
            end
            i_d     = 4'd15;
            state_d = StShuffle;
         end
         StShuffle: begin
            lfsr_step = 1'b1;
            // j above i is rejected rather than reduced, keeping the shuffle unbiased
            if (j <= i_q) begin
               tile_d[i_q] = tile_q[j];
               tile_d[j]   = tile_q[i_q];
               i_d         = i_q - 4'd1;
               if (i_q == 4'd1) begin
                  k_d     = 4'd0;
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            we_d    = 1'b1;
            addr_d  = k_q;
            wdata_d = make_word(tile_q[k_q], (k_q == 4'd0));
            k_d     = k_q + 4'd1;
            if (k_q == 4'd15) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_d        = 1'b1;
            board_ready_d = 1'b1;
            state_d       = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   // State, tile array, indices, free-running counter and output registers
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q       <= StIdle;
         for (int t = 0; t < NUM_TILES; t++) begin
            tile_q[t] <= 3'd0;
         end
         i_q           <= 4'd0;
         k_q           <= 4'd0;
         cnt_q         <= 16'd0;
         addr_q        <= 4'd0;
         wdata_q       <= 8'd0;
         we_q          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         board_ready_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         tile_q        <= tile_d;
         i_q           <= i_d;
         k_q           <= k_d;
         cnt_q         <= cnt_q + 16'd1;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         we_q          <= we_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         board_ready_q <= board_ready_d;
      end
   end

   assign addr_o        = addr_q;
   assign wdata_o       = wdata_q;
   assign we_o          = we_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign board_ready_o = board_ready_q;

endmodule
